// File: rtl/shift_right_seq_32bit.sv
// ----------------------------------------------------------------------------
// shift_right_seq_32bit
//
// Multi-cycle 32-bit right shifter for the miniMIPS datapath (srl, sra, srlv,
// srav). One bit position is shifted per clock under a start/done handshake.
//
//   op = 00 : logical right
//   op = 01 : arithmetic right
//   op = 10 : rotate right when SHIFT_RIGHT_ROTATE_EN is defined,
//             otherwise identical to logical right
//   op = 11 : reserved, treated as logical right
//
// Configuration macro: SHIFT_RIGHT_ROTATE_EN (undefined by default; when
// undefined no rotate logic is compiled). Ports are identical in both builds.
//
// Timing: the edge that accepts start is edge 1; done is high in the cycle
// after edge shamt+1. busy covers the SHIFT and DONE states. All outputs are
// decoded from registers only, so there is no input-to-output combinational
// path.
// ----------------------------------------------------------------------------
module shift_right_seq_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Shift flavour, resolved once when start is accepted so the SHIFT loop
    // never has to re-decode the raw op code (including the reserved value).
    typedef enum logic [1:0] {
        M_LOGICAL = 2'd0,
        M_ARITH   = 2'd1,
        M_ROTATE  = 2'd2
    } mode_t;

    state_t      state_q,  state_d;
    mode_t       mode_q,   mode_d;
    logic [4:0]  count_q,  count_d;
    logic [31:0] result_q, result_d;

    mode_t       mode_in;   // decoded op at the input
    logic        fill_bit;  // bit entering position 31 on each shift step

    // Decode the incoming op into a shift mode; reserved code maps to logical.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves a combinational output unassigned would infer a latch.
        mode_in = M_LOGICAL;
        unique case (op)
            2'b01:   mode_in = M_ARITH;
`ifdef SHIFT_RIGHT_ROTATE_EN
            2'b10:   mode_in = M_ROTATE;
`else
            2'b10:   mode_in = M_LOGICAL;
`endif
            default: mode_in = M_LOGICAL;
        endcase
    end

    // Select the bit shifted into the MSB for the latched mode.
    always_comb begin
        fill_bit = 1'b0;
        unique case (mode_q)
            M_ARITH:  fill_bit = result_q[31];
`ifdef SHIFT_RIGHT_ROTATE_EN
            M_ROTATE: fill_bit = result_q[0];
`endif
            default:  fill_bit = 1'b0;
        endcase
    end

    // Next-state and datapath control for the IDLE / SHIFT / DONE sequence.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    count_d  = shamt;
                    mode_d   = mode_in;
                    state_d  = (shamt == 5'd0) ? S_DONE : S_SHIFT;
                end
            end

            S_SHIFT: begin
                // start is ignored here: no reload and nothing queued.
                result_d = {fill_bit, result_q[31:1]};
                count_d  = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // result is held until the next accepted start.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= M_LOGICAL;
            count_q  <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_right_seq_32bit.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for shift_right_seq_32bit.
// Expected values are hand-computed constants. Rotate expectations follow
// SHIFT_RIGHT_ROTATE_EN so the bench works for either build.
// ----------------------------------------------------------------------------
module tb_shift_right_seq_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_right_seq_32bit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .data_in (data_in),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one operation and follow it to completion. Checks the edge on
    // which done appears (shamt+1), the result, the single-cycle done pulse,
    // busy falling and the result being held afterwards.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [4:0] s, input logic [31:0] d,
                          input logic [31:0] exp_result);
        int edges;
        op      = o;
        shamt   = s;
        data_in = d;
        start   = 1'b1;
        tick();                       // edge 1 accepts start
        start   = 1'b0;
        op      = 2'b11;              // don't-care after acceptance
        shamt   = 5'd17;
        data_in = 32'hDEAD_BEEF;
        check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        edges = 1;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check({tag, "_done_edge"}, edges, {27'd0, s} + 32'd1);
        check({tag, "_result"}, result, exp_result);
        tick();
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_result_hold"}, result, exp_result);
    endtask

    initial begin
        int edges;
        int done_seen;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        shamt   = 5'd0;
        data_in = 32'd0;
        tick();
        tick();

        // Reset state.
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Reset and start in the same cycle: reset wins.
        start   = 1'b1;
        shamt   = 5'd3;
        data_in = 32'hFFFF_FFFF;
        tick();
        start   = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        check("rst_start_result", result, 32'd0);
        reset = 1'b0;
        tick();

        // Main directed vectors (each issued in the first cycle busy is low).
        run_op("lsr2",    2'b00, 5'd2,  32'h0C0F_0C0F, 32'h0303_C303);
        run_op("asr31n",  2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("asr31p",  2'b01, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000);
        run_op("zero",    2'b00, 5'd0,  32'h1D0F_FCFB, 32'h1D0F_FCFB);
        run_op("asr4",    2'b01, 5'd4,  32'hF000_0000, 32'hFF00_0000);
        run_op("rsvd11",  2'b11, 5'd4,  32'h8000_0000, 32'h0800_0000);
        run_op("lsr31",   2'b00, 5'd31, 32'h8000_0000, 32'h0000_0001);
`ifdef SHIFT_RIGHT_ROTATE_EN
        run_op("rot4",    2'b10, 5'd4,  32'h0000_000F, 32'hF000_0000);
        run_op("rot1",    2'b10, 5'd1,  32'h0000_0001, 32'h8000_0000);
`else
        run_op("rot4",    2'b10, 5'd4,  32'h0000_000F, 32'h0000_0000);
        run_op("rot1",    2'b10, 5'd1,  32'h8000_0001, 32'h4000_0000);
`endif

        // start while busy is ignored.
        op      = 2'b00;
        shamt   = 5'd8;
        data_in = 32'hFF00_0000;
        start   = 1'b1;
        tick();                                   // edge 1
        start   = 1'b0;
        tick();                                   // edge 2
        tick();                                   // edge 3
        op      = 2'b01;
        shamt   = 5'd1;
        data_in = 32'h1234_5678;
        start   = 1'b1;
        tick();                                   // edge 4, ignored
        start   = 1'b0;
        edges = 4;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check("busy_ign_done_edge", edges, 32'd9);
        check("busy_ign_result", result, 32'h00FF_0000);
        tick();

        // Reset mid-shift.
        op      = 2'b00;
        shamt   = 5'd20;
        data_in = 32'hAAAA_5555;
        start   = 1'b1;
        tick();                                   // edge 1
        start   = 1'b0;
        tick(); tick(); tick(); tick();           // edges 2..5
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();                                   // edge 6
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 32'd0);

        // Normal operation after the reset.
        run_op("post_rst", 2'b01, 5'd3, 32'h8000_0010, 32'hF000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_right_seq_32bit.md
# shift_right_seq_32bit

Multi-cycle 32-bit right shifter for the miniMIPS datapath. It is the right-shift counterpart to the combinational left-shift-by-2 path, serving `srl`, `sra`, `srlv` and `srav`. It shifts one bit position per clock under a start/done handshake. The multi-cycle control unit holds its state until `done`.

## Interface
Parameters
- none (width fixed at 32; shift amount fixed at 5 bits)

Ports
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  request pulse; accepted only when `busy`=0
- `op`  in  2  00 logical right, 01 arithmetic right, 10 rotate right (see Configuration), 11 reserved (treated as 00)
- `shamt`  in  5  shift amount 0..31, sampled with `start`
- `data_in`  in  32  operand, sampled with `start`
- `result`  out  32  working/result register
- `busy`  out  1  high in SHIFT and DONE states
- `done`  out  1  one-cycle pulse; `result` is valid while high

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE
  - `start`=1: load `result`<=`data_in`, `count`<=`shamt`, latch `op`.
  - Go to DONE if `shamt`=0, else go to SHIFT.
- SHIFT, each cycle:
  - Logical: `result`<={1'b0, result[31:1]}.
  - Arithmetic: `result`<={result[31], result[31:1]}.
  - Rotate: `result`<={result[0], result[31:1]}.
  - Decrement `count`. The shift taken with `count`=1 is the last one; then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `result` holds its value after DONE until the next accepted `start`.
- `start` while `busy`=1 is ignored: no reload, no queueing.
- `op`, `shamt` and `data_in` are don't-care except in the cycle `start` is accepted.
- Reset, including mid-SHIFT:
  - State goes to IDLE.
  - `result`=0, `count`=0, `busy`=0, `done`=0.
  - The in-flight operation is discarded and no `done` is emitted.
- Reset and `start` in the same cycle: reset wins.

## Timing
- The edge that accepts `start` is edge 1.
- `done` is high in the cycle following edge max(`shamt`,0)+1.
  - `shamt`=0: `done` is high the cycle right after acceptance.
  - `shamt`=31: `done` is high after edge 32.
- `busy` rises after edge 1 and falls after the edge that leaves DONE.
- Throughput: a new `start` is accepted in the first cycle `busy`=0, i.e. the cycle after `done`.
  - Minimum issue interval: `shamt`+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SHIFT_RIGHT_ROTATE_EN`.
- Defined:
  - `op`=10 performs rotate right; bit 0 wraps into bit 31 each step.
- Undefined:
  - No rotate logic is compiled.
  - `op`=10 behaves exactly as `op`=00 (logical).
- Ports are identical in both builds.

## Test plan
- Logical shift: `op`=00, `shamt`=2, `data_in`=0x0C0F0C0F.
  - `done` after edge 3; `result`=0x0303C303.
- Arithmetic shift, maximum amount: `op`=01, `shamt`=31, `data_in`=0x80000000.
  - `done` after edge 32; `result`=0xFFFFFFFF.
  - Same with `data_in`=0x7FFFFFFF gives 0x00000000.
- Zero shift: `op`=00, `shamt`=0, `data_in`=0x1D0FFCFB.
  - `done` the cycle after acceptance; `result`=0x1D0FFCFB.
  - `busy` is high for exactly 1 cycle.
- Rotate: `op`=10, `shamt`=4, `data_in`=0x0000000F.
  - With macro defined: `result`=0xF0000000.
  - Without macro: `result`=0x00000000.
- `start` while busy is ignored:
  - Start `shamt`=8, `data_in`=0xFF000000 (logical).
  - Pulse `start` with 0x12345678 at edge 4.
  - `done` still arrives after edge 9 with `result`=0x00FF0000.
- Reset mid-shift:
  - Start `shamt`=20, assert `reset` at edge 6.
  - Next cycle: `busy`=0, `done`=0, `result`=0, and no `done` pulse follows.
  - A new `start` in the cycle after reset deasserts completes normally.
